shift_add_mult_arbiter: RTL and testbench

Shares one iterative shift-and-add multiplier core between two requesters. Arbitrates round-robin, accepts one operand pair, and computes the product over exactly N clock cycles, one multiplier bit per cycle. Returns the product tagged with the requester ID over a valid/ready result port. It sits between the operand-producing blocks and the result consumer, replacing per-requester combinational multipliers with a single time-shared sequential datapath.

---
 rtl/shift_add_mult_arbiter.sv | 140 ++++++++++++++
 tb/tb_shift_add_mult_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_arbiter.sv
// Two requesters share one shift-and-add multiplier; round-robin grant, N cycles per product.
// Latency N+1 from accept to res_valid; result held in DONE while res_ready is low, blocking new accepts.
module shift_add_mult_arbiter #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [M-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [M-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [M+N-1:0]   res_p,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy
);

  localparam int P  = M + N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [P-1:0]  mcand;
  logic [P-1:0]  acc;
  logic [N-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic          id;
  logic          ptr;
  logic          grant;
  logic          accept;
  logic          take;
  logic          last_iter;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant = ptr;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign take       = (state == DONE) && res_ready;
  assign last_iter  = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      id     <= 1'b0;
      ptr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= grant ? P'(req1_a) : P'(req0_a);
            mplier <= grant ? req1_b : req0_b;
            acc    <= '0;
            cnt    <= '0;
            id     <= grant;
          end
        end
        RUN: begin
          // Fixed N iterations regardless of operand values.
          if (mplier[cnt]) begin
            acc <= acc + (mcand << cnt);
          end
          cnt <= last_iter ? '0 : cnt + CW'(1);
        end
        DONE: begin
          if (take) begin
            ptr <= ~id;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign res_p     = acc;
  assign res_id    = id;
  assign busy      = (state != IDLE);

  a_one_ready: assert property (@(posedge clk) !(req0_ready && req1_ready));

  a_res_hold: assert property (@(posedge clk) disable iff (rst)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_p) && $stable(res_id)));

endmodule

// File: tb/tb_shift_add_mult_arbiter.sv
// Bench for shift_add_mult_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_shift_add_mult_arbiter;

  localparam int M = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic [M-1:0]   req0_a, req1_a;
  logic [N-1:0]   req0_b, req1_b;
  logic           req0_ready, req1_ready;
  logic           res_valid, res_id, res_ready, busy;
  logic [M+N-1:0] res_p;

  always #5 clk = ~clk;

  shift_add_mult_arbiter #(.M(M), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_p      (res_p),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Transaction-level model: one outstanding product, due N+1 cycles after its accept.
  int  cyc     = 0;
  bit  pend    = 0;
  int  acc_cyc = 0;
  int  exp_p   = 0;
  bit  exp_id  = 0;
  bit  m_ptr   = 0;

  bit  acc_ev, acc_id, hs_ev, rv_seen;
  int  last_p, last_id, last_lat;
  int  nres = 0;

  task automatic step();
    logic g, e0, e1, ev, r;
    int   a, b;
    @(negedge clk);
    r  = rst;
    g  = (req0_valid && !req1_valid) ? 1'b0 :
         (req1_valid && !req0_valid) ? 1'b1 : m_ptr;
    e0 = !pend && req0_valid && !g;
    e1 = !pend && req1_valid && g;
    ev = pend && (cyc - acc_cyc >= N + 1);
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("busy", busy, pend);
    check("res_valid", res_valid, ev);
    if (ev) begin
      check("res_p", res_p, exp_p);
      check("res_id", res_id, exp_id);
    end
    rv_seen = res_valid;
    acc_ev  = (e0 || e1) && !r;
    acc_id  = e1;
    a       = e1 ? int'(req1_a) : int'(req0_a);
    b       = e1 ? int'(req1_b) : int'(req0_b);
    hs_ev   = ev && res_ready && !r;
    if (hs_ev) begin
      last_p   = int'(res_p);
      last_id  = int'(res_id);
      last_lat = cyc - acc_cyc;
    end
    @(posedge clk);
    #1;
    if (r) begin
      pend  = 0;
      m_ptr = 0;
    end else begin
      if (hs_ev) begin
        pend  = 0;
        m_ptr = !exp_id;
        nres++;
      end
      if (acc_ev) begin
        pend    = 1;
        acc_cyc = cyc;
        exp_p   = a * b;
        exp_id  = acc_id;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic who, input int a, input int b);
    bit done = 0;
    if (!who) begin
      req0_valid = 1'b1; req0_a = M'(a); req0_b = N'(b);
    end else begin
      req1_valid = 1'b1; req1_a = M'(a); req1_b = N'(b);
    end
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (acc_ev && acc_id == who) done = 1;
    end
    if (!who) req0_valid = 1'b0;
    else      req1_valid = 1'b0;
    check("send_accepted", done, 1);
  endtask

  task automatic wait_result();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      done = hs_ev;
    end
    check("result_seen", done, 1);
  endtask

  int  tie_p[2];
  int  tie_id[2];
  int  tie_first;

  task automatic tie(input int a0, input int b0, input int a1, input int b1);
    int n = 0;
    bit first = 1;
    req0_valid = 1'b1; req0_a = M'(a0); req0_b = N'(b0);
    req1_valid = 1'b1; req1_a = M'(a1); req1_b = N'(b1);
    for (int i = 0; i < 60 && n < 2; i++) begin
      step();
      if (acc_ev) begin
        if (first) tie_first = int'(acc_id);
        first = 0;
        if (acc_id) req1_valid = 1'b0;
        else        req0_valid = 1'b0;
      end
      if (hs_ev) begin
        tie_p[n]  = last_p;
        tie_id[n] = last_id;
        n++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("tie_both_done", n, 2);
  endtask

  initial begin
    int k;
    int ea[4] = '{0, 15, 1, 15};
    int eb[4] = '{15, 0, 1, 15};
    int ep[4] = '{0, 0, 1, 225};

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("reset_res_p", res_p, 0);
    check("reset_res_id", res_id, 0);

    // Single request
    send(0, 13, 11);
    wait_result();
    check("single_p", last_p, 143);
    check("single_id", last_id, 0);
    check("single_latency", last_lat, N + 1);

    // Ties after reset, then a second tie that requester 0 wins again
    do_reset();
    tie(3, 5, 7, 9);
    check("tie1_first", tie_first, 0);
    check("tie1_p0", tie_p[0], 15);
    check("tie1_id0", tie_id[0], 0);
    check("tie1_p1", tie_p[1], 63);
    check("tie1_id1", tie_id[1], 1);
    tie(2, 3, 4, 5);
    check("tie2_first", tie_first, 0);
    check("tie2_p0", tie_p[0], 6);
    check("tie2_p1", tie_p[1], 20);

    // Backpressure
    res_ready = 1'b0;
    send(1, 15, 15);
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd3;
    for (int i = 0; i < 20 && !rv_seen; i++) step();
    check("bp_res_valid_seen", rv_seen, 1);
    repeat (10) step();
    check("bp_res_p", res_p, 225);
    check("bp_res_id", res_id, 1);
    check("bp_req0_ready", req0_ready, 0);
    res_ready = 1'b1;
    step();
    check("bp_handshake", hs_ev, 1);
    step();
    check("bp_next_accept", acc_ev && acc_id == 0, 1);
    req0_valid = 1'b0;
    wait_result();
    check("bp_followup_p", last_p, 15);

    // Edge operands
    for (int i = 0; i < 4; i++) begin
      send(0, ea[i], eb[i]);
      wait_result();
      check("edge_p", last_p, ep[i]);
      check("edge_latency", last_lat, N + 1);
    end

    // Reset during the second RUN cycle
    send(0, 9, 9);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_res_valid", res_valid, 0);
    k = nres;
    repeat (12) step();
    check("midrst_no_result", nres, k);
    send(0, 2, 3);
    wait_result();
    check("midrst_fresh_p", last_p, 6);

    // Operand changes after accept
    send(0, 6, 7);
    for (int i = 0; i < 3; i++) begin
      req0_a = M'($urandom);
      req0_b = N'($urandom);
      step();
    end
    wait_result();
    check("late_change_p", last_p, 42);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      res_ready = ($urandom_range(9) < 7);
      rst       = ($urandom_range(249) == 0);
      if (!req0_valid) begin
        req0_a = M'($urandom); req0_b = N'($urandom);
        req0_valid = $urandom_range(1);
      end
      if (!req1_valid) begin
        req1_a = M'($urandom); req1_b = N'($urandom);
        req1_valid = $urandom_range(1);
      end
      step();
      if (acc_ev) begin
        if (acc_id) req1_valid = 1'b0;
        else        req0_valid = 1'b0;
      end
    end
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b1;
    repeat (N + 4) step();
    check("drain_idle", busy, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
